// File: rtl/clk_tx_pkg.sv
// Shared types and constants for the link test clock transmitter.
package clk_tx_pkg;

  // Width of the per-phase cycle counter; phase lengths are limited to 255.
  localparam int unsigned CNT_W = 8;

  // Waveform selection presented on the mode input.
  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'd0,
    MODE_SHORT_HIGH = 2'd1,
    MODE_SHORT_LOW  = 2'd2,
    MODE_STOP       = 2'd3
  } tx_mode_t;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_STOP = 2'd3
  } tx_state_t;

endpackage

// File: rtl/clk_transmitter.sv
// Link test clock transmitter: divides clk_fpga into a square wave and can
// deliberately shorten one phase or stop the clock. Mode changes are taken
// only at period boundaries so no runt pulses are produced.
module clk_transmitter
  import clk_tx_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 50,
  parameter int unsigned SHORT_HALF  = 30
) (
  input  logic        clk_fpga,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        clk_out,
  output logic        period_done,
  output logic        running,
  output logic [1:0]  cur_mode,
  output logic [15:0] period_cnt
);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_HALF - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  tx_mode_t         cur_mode_q, cur_mode_d;
  logic [15:0]      period_cnt_q, period_cnt_d;
  logic             clk_out_q, period_done_q, running_q;
  logic             period_done_d;
  logic [CNT_W-1:0] high_last, low_last;
  tx_mode_t         mode_in;

  assign mode_in = tx_mode_t'(mode);

  // Last counter value of each phase for the mode latched for this period.
  always_comb begin
    high_last = (cur_mode_q == MODE_SHORT_HIGH) ? SHORT_LAST : HALF_LAST;
    low_last  = (cur_mode_q == MODE_SHORT_LOW)  ? SHORT_LAST : HALF_LAST;
  end

  // Next-state logic: phase counting and boundary-only mode latching.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_mode_d   = cur_mode_q;
    period_cnt_d = period_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          cur_mode_d = mode_in;
          state_d    = (mode_in == MODE_STOP) ? S_STOP : S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_q == high_last) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q == low_last) begin
          period_cnt_d = period_cnt_q + 16'd1;
          cnt_d        = '0;
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            cur_mode_d = mode_in;
            state_d    = (mode_in == MODE_STOP) ? S_STOP : S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        cnt_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (mode_in != MODE_STOP) begin
          cur_mode_d = mode_in;
          state_d    = S_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops
  // yet line up with the state they describe.
  always_comb begin
    period_done_d = (state_d == S_LOW) && (cnt_d == low_last);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cur_mode_q    <= MODE_NORMAL;
      period_cnt_q  <= '0;
      clk_out_q     <= 1'b0;
      period_done_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_mode_q    <= cur_mode_d;
      period_cnt_q  <= period_cnt_d;
      clk_out_q     <= (state_d == S_HIGH);
      period_done_q <= period_done_d;
      running_q     <= (state_d != S_IDLE);
    end
  end

  assign clk_out     = clk_out_q;
  assign period_done = period_done_q;
  assign running     = running_q;
  assign cur_mode    = cur_mode_q;
  assign period_cnt  = period_cnt_q;

endmodule

// File: tb/tb_clk_transmitter.sv
// Directed self-checking bench for clk_transmitter (HALF_PERIOD 50, SHORT_HALF 30).
module tb_clk_transmitter;

  logic        clk_fpga = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        clk_out;
  logic        period_done;
  logic        running;
  logic [1:0]  cur_mode;
  logic [15:0] period_cnt;

  int n_cmp = 0;
  int n_err = 0;

  clk_transmitter #(.HALF_PERIOD(50), .SHORT_HALF(30)) dut (
    .clk_fpga    (clk_fpga),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .clk_out     (clk_out),
    .period_done (period_done),
    .running     (running),
    .cur_mode    (cur_mode),
    .period_cnt  (period_cnt)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts consecutive sampled cycles with clk_out == lvl, starting at the
  // current sample point; pd counts period_done pulses, pd_at is the index
  // of the last one seen (-1 if none).
  task automatic run_len(input logic lvl, input int limit,
                         output int n, output int pd, output int pd_at);
    n = 0; pd = 0; pd_at = -1;
    while (clk_out === lvl && n < limit) begin
      if (period_done === 1'b1) begin
        pd++;
        pd_at = n;
      end
      n++;
      @(negedge clk_fpga);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, pd, pd2, pd_at, bad;

    // Reset state
    repeat (3) @(negedge clk_fpga);
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_period_done", 32'(period_done), 0);
    chk("rst_cur_mode", 32'(cur_mode), 0);
    chk("rst_period_cnt", 32'(period_cnt), 0);

    // Normal mode: 1-cycle start latency, 50/50 waveform, 10 periods
    rst = 1'b0; enable = 1'b1; mode = 2'd0;
    @(negedge clk_fpga);
    chk("start_clk_out", 32'(clk_out), 1);
    chk("start_running", 32'(running), 1);
    bad = 0;
    for (int p = 0; p < 10; p++) begin
      run_len(1'b1, 200, hi, pd, pd_at);
      run_len(1'b0, 200, lo, pd2, pd_at);
      if (p == 0) begin
        chk("norm_high_len", 32'(hi), 50);
        chk("norm_high_pd", 32'(pd), 0);
        chk("norm_low_len", 32'(lo), 50);
        chk("norm_pd_count", 32'(pd2), 1);
        chk("norm_pd_pos", 32'(pd_at), 49);
      end else if (hi != 50 || lo != 50 || pd != 0 || pd2 != 1) begin
        bad++;
      end
    end
    chk("norm_bad_periods", 32'(bad), 0);
    chk("norm_period_cnt10", 32'(period_cnt), 10);

    // SHORT_HIGH from the start
    rst = 1'b1; enable = 1'b0;
    repeat (2) @(negedge clk_fpga);
    rst = 1'b0; enable = 1'b1; mode = 2'd1;
    @(negedge clk_fpga);
    chk("sh_clk_out", 32'(clk_out), 1);
    chk("sh_cur_mode", 32'(cur_mode), 1);
    run_len(1'b1, 200, hi, pd, pd_at);
    run_len(1'b0, 200, lo, pd2, pd_at);
    chk("sh_high_len", 32'(hi), 30);
    chk("sh_low_len", 32'(lo), 50);
    chk("sh_pd_pos", 32'(pd_at), 49);

    // Mode change during HIGH is deferred to the next period
    mode = 2'd0;
    chk("defer_cur_mode_old", 32'(cur_mode), 1);
    run_len(1'b1, 200, hi, pd, pd_at);
    run_len(1'b0, 200, lo, pd2, pd_at);
    chk("defer_high_len", 32'(hi), 30);
    chk("defer_low_len", 32'(lo), 50);
    chk("defer_cur_mode_new", 32'(cur_mode), 0);

    // SHORT_LOW: current normal period completes, then 50/30
    mode = 2'd2;
    run_len(1'b1, 200, hi, pd, pd_at);
    run_len(1'b0, 200, lo, pd2, pd_at);
    chk("pre_sl_high_len", 32'(hi), 50);
    chk("pre_sl_low_len", 32'(lo), 50);
    chk("sl_cur_mode", 32'(cur_mode), 2);
    run_len(1'b1, 200, hi, pd, pd_at);
    run_len(1'b0, 200, lo, pd2, pd_at);
    chk("sl_high_len", 32'(hi), 50);
    chk("sl_low_len", 32'(lo), 30);
    chk("sl_pd_pos", 32'(pd_at), 29);
    chk("sl_pd_count", 32'(pd2), 1);

    // STOP while running: SHORT_LOW period completes, then clock held low
    mode = 2'd3;
    run_len(1'b1, 200, hi, pd, pd_at);
    chk("stop_last_high_len", 32'(hi), 50);
    repeat (30) @(negedge clk_fpga);
    chk("stop_clk_out", 32'(clk_out), 0);
    chk("stop_running", 32'(running), 1);
    chk("stop_cur_mode", 32'(cur_mode), 3);
    chk("stop_period_cnt", 32'(period_cnt), 5);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (clk_out !== 1'b0 || period_cnt !== 16'd5 || period_done !== 1'b0) bad++;
      @(negedge clk_fpga);
    end
    chk("stop_held_bad", 32'(bad), 0);
    mode = 2'd0;
    @(negedge clk_fpga);
    chk("resume_clk_out", 32'(clk_out), 1);
    chk("resume_cur_mode", 32'(cur_mode), 0);

    // enable dropped 10 cycles into HIGH: full period completes, then idle
    repeat (10) @(negedge clk_fpga);
    enable = 1'b0;
    run_len(1'b1, 200, hi, pd, pd_at);
    chk("drop_rest_high", 32'(hi), 40);
    lo = 0; pd2 = 0;
    while (running === 1'b1 && lo < 200) begin
      if (clk_out !== 1'b0) bad++;
      if (period_done === 1'b1) pd2++;
      lo++;
      @(negedge clk_fpga);
    end
    chk("drop_low_len", 32'(lo), 50);
    chk("drop_pd_count", 32'(pd2), 1);
    chk("drop_running", 32'(running), 0);
    chk("drop_clk_out", 32'(clk_out), 0);
    chk("drop_period_cnt", 32'(period_cnt), 6);

    // rst at cnt = 20 of HIGH aborts immediately
    enable = 1'b1; mode = 2'd0;
    @(negedge clk_fpga);
    repeat (20) @(negedge clk_fpga);
    chk("pre_rst_clk_out", 32'(clk_out), 1);
    rst = 1'b1;
    @(negedge clk_fpga);
    chk("abort_clk_out", 32'(clk_out), 0);
    chk("abort_running", 32'(running), 0);
    chk("abort_period_cnt", 32'(period_cnt), 0);
    rst = 1'b0;

    // period_cnt wrap 65535 -> 0
    @(negedge clk_fpga);
    repeat (5) @(negedge clk_fpga);
    force dut.period_cnt_q = 16'hFFFF;
    @(negedge clk_fpga);
    release dut.period_cnt_q;
    chk("wrap_pre", 32'(period_cnt), 32'hFFFF);
    run_len(1'b1, 200, hi, pd, pd_at);
    run_len(1'b0, 200, lo, pd2, pd_at);
    chk("wrap_rest_high", 32'(hi), 44);
    chk("wrap_low_len", 32'(lo), 50);
    chk("wrap_period_cnt", 32'(period_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_transmitter.md
Name: clk_transmitter

Overview:
Generates the 1 MHz link test clock from the 100 MHz FPGA clock, i.e. the driving end of the clock-status monitor link. The block drives a clean square wave in normal mode and deliberately malformed waveforms in fault modes (short high, short low, stopped clock). This lets the status monitor's pulse-width and watchdog checks be exercised in-system.
All timing is counted in clk_fpga cycles. Mode changes apply only at period boundaries, so no runt pulses are ever emitted.

Parameters:
HALF_PERIOD, 50, cycles per phase in normal operation (50 = 1 MHz at 100 MHz)
SHORT_HALF, 30, cycles for the shortened phase in fault modes; constraint 1 <= SHORT_HALF < HALF_PERIOD <= 255

Ports:
clk_fpga  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
enable  input  1  1 = generate clock; 0 = finish current period then idle
mode  input  2  0 NORMAL, 1 SHORT_HIGH, 2 SHORT_LOW, 3 STOP; sampled only at boundaries
clk_out  output  1  generated clock to the LVDS driver
period_done  output  1  one-cycle pulse in the last low cycle of each completed period
running  output  1  1 whenever state != IDLE
cur_mode  output  2  mode latched for the current period
period_cnt  output  16  completed periods since reset; wraps 65535 -> 0

Behaviour:
- Interface: one clock, clk_fpga; reset rst is synchronous and active-high.
- Reset values: state IDLE, clk_out 0, period_done 0, running 0, cur_mode 0, period_cnt 0, phase counter 0. rst asserted mid-period aborts immediately; clk_out is 0 on the next cycle.
- FSM states: IDLE, HIGH, LOW, STOP. 8-bit phase counter cnt.
- Phase lengths:
  - high_len = SHORT_HALF if cur_mode == SHORT_HIGH, else HALF_PERIOD.
  - low_len = SHORT_HALF if cur_mode == SHORT_LOW, else HALF_PERIOD.
- IDLE:
  - clk_out = 0.
  - If enable = 1 in cycle N, latch cur_mode <= mode.
  - If mode = STOP, go to STOP; otherwise go to HIGH with cnt = 0, and clk_out = 1 from cycle N+1. Latency from enable to first rising edge is 1 cycle.
- HIGH:
  - clk_out = 1; cnt increments each cycle.
  - When cnt == high_len-1, go to LOW with cnt = 0. clk_out is therefore high for exactly high_len cycles.
- LOW:
  - clk_out = 0; cnt increments each cycle.
  - When cnt == low_len-1: period_done = 1 this cycle, and period_cnt increments on the next edge.
  - Then, at this boundary:
    - enable = 0: go to IDLE.
    - enable = 1 and mode = STOP: latch cur_mode and go to STOP.
    - enable = 1 otherwise: latch cur_mode <= mode and go to HIGH, cnt = 0.
- STOP:
  - clk_out held 0; no periods are counted.
  - Each cycle:
    - enable = 0: go to IDLE.
    - mode != STOP: latch mode, go to HIGH, cnt = 0.
    - otherwise remain in STOP.
- enable deasserted mid-HIGH or mid-LOW: the current period always completes with full phase lengths, with no truncation.
- A mode change mid-period is ignored until the next boundary.
- Registers: clk_out, period_done, running and cur_mode are all driven from registers; no combinational paths from inputs to outputs.

Decomposition:
- Package clk_tx_pkg holds:
  - typedef enum logic [1:0] tx_mode_t {NORMAL, SHORT_HIGH, SHORT_LOW, STOP}
  - typedef enum tx_state_t {IDLE, HIGH, LOW, STOP}
  - constant CNT_W = 8
- No sub-module: the FSM and phase counter are one flat module of about 150 lines.

Test Plan:
- rst, then enable = 1, mode = 0 held -> clk_out high for exactly 50 cycles, low for 50; period_done every 100 cycles; period_cnt = 10 after 1000 cycles.
- mode = 1 from the start -> high 30 / low 50 cycles per period; cur_mode = 1; switching to mode = 0 mid-high takes effect only at the next period.
- mode = 2 -> high 50 / low 30 cycles.
- mode = 3 while running -> current period completes; clk_out then stays 0 for 300 cycles with period_cnt frozen. Switching back to mode = 0 -> clk_out = 1 on the next cycle.
- enable dropped 10 cycles into HIGH -> high still lasts 50 cycles and low 50; period_done pulses once; running falls to 0 the following cycle.
- rst pulsed at cnt = 20 of HIGH -> next cycle clk_out = 0, running = 0, period_cnt = 0. period_cnt forced near 65535 (via long run, or a 16-bit force in simulation) -> wraps to 0.
